// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV fetch types, opcode constants and buffer depth
//
// Purpose: opcode constants, fetch FSM state enum and fetch buffer entry
//          struct shared by instruction_fetch and fetch_buffer.
// Config : FETCH_BUFFER_EN defined -> 2-entry fetch FIFO,
//          undefined -> 1-entry holding register.
package rv_pkg;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
  // addi x0, x0, 0
  localparam logic [31:0] OP_NOP    = 32'h0000_0013;

`ifdef FETCH_BUFFER_EN
  localparam int FETCH_DEPTH = 2;
`else
  localparam int FETCH_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

  // Word step with natural 32-bit wrap.
  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small {pc, instruction} FIFO between fetch and decode
//
// Purpose: holds fetched entries; DEPTH is 1 or 2.
// Ports  : clk, rst      - clock, synchronous active-high reset
//          flush         - drop all entries (redirect)
//          push, push_entry - write one entry
//          pop           - remove head entry
//          head          - current head entry (valid when !empty)
//          full, empty, count - occupancy
module fetch_buffer
  import rv_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  // Two slots are always declared; the 1-entry build only ever uses slot 0.
  fetch_entry_t r_mem [0:1];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign empty = (r_count == 2'd0);
  assign full  = (r_count == DEPTH_C);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A push into a full buffer is legal when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  function automatic logic next_ptr(input logic p);
    return (DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV instruction fetch unit with redirect support
//
// Purpose: issues word fetches to instruction memory (one outstanding at a
//          time), buffers {pc, instruction} and presents them to the datapath.
// Config : FETCH_BUFFER_EN selects a 2-entry buffer (default: 1 entry).
// Ports  : clk, rst                         - clock, sync active-high reset
//          imem_req_valid/ready/addr        - fetch request handshake
//          imem_rsp_valid/data              - fetch response
//          instr_valid/ready, instruction   - instruction handshake
//          pc, pcNext                       - presented pc and pc + 4
//          redirect_valid/target            - taken jump/branch
module instruction_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pcNext,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  fetch_state_t r_state;
  logic [31:0]  r_fpc;
  logic         r_outstanding;
  logic         r_discard;

  logic         w_req_fire;
  logic         w_rsp_take;
  logic         w_push;
  logic         w_pop;
  logic         w_still_out;
  logic         w_space_after;
  logic         w_full;
  logic         w_empty;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;
  logic [1:0]   w_unused_tgt_lsbs;

  assign w_unused_tgt_lsbs = redirect_target[1:0];

  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_fpc;

  assign w_req_fire = (r_state == REQ) && imem_req_ready;
  // Responses only count while a request is actually in flight.
  assign w_rsp_take = imem_rsp_valid && r_outstanding;
  assign w_pop      = !w_empty && instr_ready && !redirect_valid;
  assign w_push     = w_rsp_take && !r_discard && !redirect_valid;

  // The request in flight carries pc = fpc - 4 (fpc advanced on acceptance).
  assign w_push_entry.pc          = r_fpc - 32'd4;
  assign w_push_entry.instruction = imem_rsp_data;

  // On redirect: is a response still owed by memory after this edge?
  assign w_still_out = (r_outstanding && !imem_rsp_valid) || w_req_fire;

  // Occupancy after this cycle's push and pop, compared against depth.
  assign w_space_after =
    (({1'b0, w_count} + 3'd1) - {2'b00, w_pop}) < 3'(FETCH_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_fpc         <= RESET_PC;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else if (redirect_valid) begin
      r_fpc <= {redirect_target[31:2], 2'b00};
      if (w_still_out) begin
        r_state       <= WAIT;
        r_outstanding <= 1'b1;
        r_discard     <= 1'b1;
      end else begin
        r_state       <= REQ;
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (imem_req_ready) begin
            r_fpc         <= pc_plus4(r_fpc);
            r_outstanding <= 1'b1;
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          if (w_rsp_take) begin
            r_outstanding <= 1'b0;
            if (r_discard) begin
              // Buffer was flushed by the redirect, so room is guaranteed.
              r_discard <= 1'b0;
              r_state   <= REQ;
            end else if (w_space_after) begin
              r_state <= REQ;
            end else begin
              r_state <= FULL;
            end
          end
        end
        FULL: begin
          if (w_pop) begin
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH (FETCH_DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count)
  );

  // An empty buffer presents a NOP at RESET_PC so the outputs are never X.
  assign instr_valid = !w_empty;
  assign instruction = w_empty ? OP_NOP : w_head.instruction;
  assign pc          = w_empty ? RESET_PC : w_head.pc;
  assign pcNext      = pc_plus4(pc);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

`ifdef FETCH_BUFFER_EN
  localparam int TB_DEPTH = 2;
`else
  localparam int TB_DEPTH = 1;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  int n_vec;
  int n_err;
  bit mem_auto;

  instruction_fetch #(
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .pc              (pc),
    .pcNext          (pcNext),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; in auto mode memory answers an accepted request next cycle.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      imem_rsp_valid = acc;
      imem_rsp_data  = acc ? mem_word(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    tick();
    tick();
    imem_rsp_valid = 1'b0;
    rst            = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    int          got;
    int          budget;

    n_vec           = 0;
    n_err           = 0;
    mem_auto        = 1'b1;
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    #1;

    // Reset state
    do_reset();
    check("rst_req_valid",   {31'b0, imem_req_valid}, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid},    32'h0);
    check("rst_instruction", instruction,             32'h0000_0013);
    check("rst_pc",          pc,                      32'h0000_0100);
    check("rst_pcnext",      pcNext,                  32'h0000_0104);

    // Streaming from RESET_PC with a 1-cycle memory
    instr_ready = 1'b1;
    exp_addr = 32'h100;
    exp_pc   = 32'h100;
    got      = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      if (imem_req_valid) begin
        check("stream_addr", imem_req_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (instr_valid) begin
        check("stream_pc",     pc,          exp_pc);
        check("stream_instr",  instruction, mem_word(exp_pc));
        check("stream_pcnext", pcNext,      exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
    end
    check("stream_count", got, 4);

    // Back-pressure from the datapath fills the buffer
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    check("full_instr_valid", {31'b0, instr_valid},    32'h1);
    check("full_req_valid",   {31'b0, imem_req_valid}, 32'h0);
    check("full_head_pc",     pc,                      32'h100);
    tick();
    tick();
    check("full_req_still_low", {31'b0, imem_req_valid}, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("full_after_pop_valid", {31'b0, instr_valid}, (TB_DEPTH == 2) ? 32'h1 : 32'h0);
    if (TB_DEPTH == 2) check("full_after_pop_pc", pc, 32'h104);
    check("full_after_pop_req",  {31'b0, imem_req_valid}, 32'h1);
    check("full_after_pop_addr", imem_req_addr, (TB_DEPTH == 2) ? 32'h108 : 32'h104);

    // Memory not ready for 5 cycles
    do_reset();
    imem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check("stall_addr",      imem_req_addr,           32'h100);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    check("stall_accepted", {31'b0, imem_req_valid}, 32'h0);
    tick();
    check("stall_pc",    pc,          32'h100);
    check("stall_instr", instruction, mem_word(32'h100));

    // Redirect while a response is outstanding
    mem_auto = 1'b0;
    do_reset();
    tick();
    tick();
    check("redir_wait", {31'b0, imem_req_valid}, 32'h0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    check("redir_req_low",    {31'b0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    mem_auto       = 1'b1;
    check("redir_dropped",  {31'b0, instr_valid},    32'h0);
    check("redir_req",      {31'b0, imem_req_valid}, 32'h1);
    check("redir_addr",     imem_req_addr,           32'h200);
    tick();
    tick();
    check("redir_new_valid", {31'b0, instr_valid}, 32'h1);
    check("redir_new_pc",    pc,                   32'h200);
    check("redir_new_instr", instruction,          mem_word(32'h200));

    // Redirect with simultaneous consume on a full buffer
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    check("rc_full", {31'b0, instr_valid}, 32'h1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0400;
    instr_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    check("rc_flushed", {31'b0, instr_valid}, 32'h0);
    check("rc_addr",    imem_req_addr,        32'h400);
    tick();
    tick();
    check("rc_new_pc",     pc,          32'h400);
    check("rc_new_pcnext", pcNext,      32'h404);
    check("rc_new_instr",  instruction, mem_word(32'h400));

    // Reset during WAIT, then a late response
    mem_auto = 1'b0;
    do_reset();
    tick();
    tick();
    check("rw_wait", {31'b0, imem_req_valid}, 32'h0);
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    mem_auto       = 1'b1;
    check("rw_ignored", {31'b0, instr_valid},    32'h0);
    check("rw_req",     {31'b0, imem_req_valid}, 32'h1);
    check("rw_addr",    imem_req_addr,           32'h100);
    tick();
    tick();
    check("rw_pc",    pc,          32'h100);
    check("rw_instr", instruction, mem_word(32'h100));

    // Fetch PC wrap at the top of the address space
    do_reset();
    instr_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_pc",     pc,     32'hFFFF_FFFC);
    check("wrap_pcnext", pcNext, 32'h0000_0000);
    budget = 0;
    while (!imem_req_valid && budget < 5) begin
      tick();
      budget++;
    end
    check("wrap_req_seen", {31'b0, imem_req_valid}, 32'h1);
    check("wrap_next_addr", imem_req_addr, 32'h0000_0000);
    instr_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
